token_rcv_ctrl: RTL and testbench

TOKEN_RCV_CTRL -- requirements
Module: token_rcv_ctrl

---
 rtl/token_rcv_ctrl_pkg.sv | 34 +++
 rtl/token_rcv_ctrl_if.sv | 25 ++
 rtl/token_rcv_ctrl_crc5_serial.sv | 37 +++
 rtl/token_rcv_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_token_rcv_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/token_rcv_ctrl_pkg.sv
// Shared types and constants for the token receive controller.
// Holds the FSM state encoding, token PID values and CRC5 parameters.
package token_rcv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_B1   = 3'd1,
    SHIFT1   = 3'd2,
    GET_B2   = 3'd3,
    SHIFT2   = 3'd4,
    WAIT_EOP = 3'd5,
    CHECK    = 3'd6,
    IGNORE   = 3'd7
  } state_e;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  // Upper nibble of a PID byte is the one's complement of the lower nibble.
  function automatic logic pid_check_ok(input logic [7:0] pid_byte);
    return pid_byte[7:4] == ~pid_byte[3:0];
  endfunction

  function automatic logic is_token_pid(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) || (pid == PID_SETUP);
  endfunction

endpackage

// File: rtl/token_rcv_ctrl_if.sv
// Byte-stream input and decoded-token output bundle of the token receiver.
// master drives the byte stream, slave is the receiver itself.
interface token_rcv_ctrl_if;

  logic       byte_valid;
  logic [7:0] rcv_byte;
  logic       eop;
  logic       token_valid;
  logic       token_err;
  logic [3:0] token_pid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic       busy;

  modport master (
    output byte_valid, rcv_byte, eop,
    input  token_valid, token_err, token_pid, token_addr, token_endp, busy
  );

  modport slave (
    input  byte_valid, rcv_byte, eop,
    output token_valid, token_err, token_pid, token_addr, token_endp, busy
  );

endinterface

// File: rtl/token_rcv_ctrl_crc5_serial.sv
// Bit-serial CRC5 (x^5 + x^2 + 1), one bit per enabled cycle.
// init has priority over shift_en; reset clears the register to zero.
module crc5_serial
  import token_rcv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       shift_en,
  input  logic       din,
  output logic [4:0] crc
);

  logic [4:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = din ^ crc_q[4];
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC5_INIT;
    end else if (shift_en) begin
      crc_d = {crc_q[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/token_rcv_ctrl.sv
// Token packet receiver: checks PID, captures addr/endp, verifies CRC5.
// state    | meaning
// IDLE     | waiting for a PID byte
// GET_B1   | waiting for addr / endp[0] byte
// SHIFT1   | feeding byte 2 through the CRC, 8 cycles
// GET_B2   | waiting for endp[3:1] / CRC byte
// SHIFT2   | feeding byte 3 through the CRC, 8 cycles
// WAIT_EOP | all bits in, waiting for end of packet
// CHECK    | compare CRC against the residual, issue result
// IGNORE   | dropping bytes until end of packet
module token_rcv_ctrl
  import token_rcv_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  token_rcv_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       eop_seen_q, eop_seen_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic       crc_init, crc_shift, crc_din, eop_now;
  logic [4:0] crc;

  crc5_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .shift_en (crc_shift),
    .din      (crc_din),
    .crc      (crc)
  );

  // Byte is held still; the counter selects the bit, LSB first.
  assign crc_din = shreg_q[bit_cnt_q];
  assign eop_now = eop_seen_q | bus.eop;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    eop_seen_d = eop_seen_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    pid_d      = pid_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    crc_init   = 1'b0;
    crc_shift  = 1'b0;

    unique case (state_q)
      IDLE: begin
        eop_seen_d = 1'b0;
        bit_cnt_d  = '0;
        if (bus.byte_valid) begin
          if (!pid_check_ok(bus.rcv_byte)) begin
            err_d   = 1'b1;
            state_d = IGNORE;
          end else if (is_token_pid(bus.rcv_byte[3:0])) begin
            pid_d    = bus.rcv_byte[3:0];
            crc_init = 1'b1;
            state_d  = GET_B1;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      GET_B1: begin
        if (bus.eop) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.byte_valid) begin
          addr_d    = bus.rcv_byte[6:0];
          endp_d[0] = bus.rcv_byte[7];
          shreg_d   = bus.rcv_byte;
          bit_cnt_d = '0;
          state_d   = SHIFT1;
        end
      end
      SHIFT1: begin
        crc_shift = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bus.eop) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (bus.byte_valid) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = IGNORE;
        end else if (bit_cnt_q == 3'd7) begin
          state_d = GET_B2;
        end
      end
      GET_B2: begin
        if (bus.eop) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.byte_valid) begin
          endp_d[3:1] = bus.rcv_byte[2:0];
          shreg_d     = bus.rcv_byte;
          bit_cnt_d   = '0;
          state_d     = SHIFT2;
        end
      end
      SHIFT2: begin
        crc_shift  = 1'b1;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        eop_seen_d = eop_now;
        if (bus.byte_valid) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = eop_now ? IDLE : IGNORE;
        end else if (bit_cnt_q == 3'd7) begin
          state_d = eop_now ? CHECK : WAIT_EOP;
        end
      end
      WAIT_EOP: begin
        if (bus.byte_valid) begin
          err_d   = 1'b1;
          state_d = bus.eop ? IDLE : IGNORE;
        end else if (bus.eop) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (crc == CRC5_RESIDUAL) begin
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      IGNORE: begin
        if (bus.eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      eop_seen_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      eop_seen_q <= eop_seen_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      pid_q      <= pid_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
    end
  end

  assign bus.token_valid = valid_q;
  assign bus.token_err   = err_q;
  assign bus.token_pid   = pid_q;
  assign bus.token_addr  = addr_q;
  assign bus.token_endp  = endp_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_token_rcv_ctrl.sv
// Directed bench for token_rcv_ctrl: vector table of whole packets plus
// hand-written sequences for result latency, overrun and mid-packet reset.
module tb_token_rcv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  token_rcv_ctrl_if bus ();

  token_rcv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;

  always @(negedge clk) begin
    if (bus.token_valid) n_valid++;
    if (bus.token_err) n_err++;
    if (bus.token_valid && bus.token_err) n_both++;
  end

  typedef struct packed {
    logic [3:0][7:0] b;
    logic [2:0]      nb;
    logic [1:0]      ev;
    logic [1:0]      ee;
    logic [3:0]      pid;
    logic [6:0]      addr;
    logic [3:0]      endp;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input logic [2:0] nb,
                              input logic [1:0] ev, ee, input logic [3:0] pid,
                              input logic [6:0] addr, input logic [3:0] endp);
    vec_t v;
    v.b    = {b3, b2, b1, b0};
    v.nb   = nb;
    v.ev   = ev;
    v.ee   = ee;
    v.pid  = pid;
    v.addr = addr;
    v.endp = endp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.rcv_byte   = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic send_eop();
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, bus.token_valid, 0);
    check({tag, " err"},   bus.token_err, 0);
    check({tag, " pid"},   bus.token_pid, 0);
    check({tag, " addr"},  bus.token_addr, 0);
    check({tag, " endp"},  bus.token_endp, 0);
    check({tag, " busy"},  bus.busy, 0);
  endtask

  initial begin
    int v0, e0;
    bus.byte_valid = 1'b0;
    bus.rcv_byte   = 8'h00;
    bus.eop        = 1'b0;

    vecs[0]  = mk(8'hA5, 8'h81, 8'h58, 8'h00, 3, 1, 0, 4'b0101, 7'd1, 4'b0001);
    vecs[1]  = mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 1, 0, 4'b1101, 7'd0, 4'b0000);
    vecs[2]  = mk(8'hE1, 8'h81, 8'h58, 8'h00, 3, 1, 0, 4'b0001, 7'd1, 4'b0001);
    vecs[3]  = mk(8'h69, 8'h00, 8'h9D, 8'h00, 3, 1, 0, 4'b1001, 7'd0, 4'b1010);
    vecs[4]  = mk(8'h2D, 8'h00, 8'h11, 8'h00, 3, 0, 1, 4'b1101, 7'd0, 4'b0010);
    vecs[5]  = mk(8'h2C, 8'h00, 8'h10, 8'h00, 3, 0, 1, 4'b1101, 7'd0, 4'b0010);
    vecs[6]  = mk(8'hD2, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'b1101, 7'd0, 4'b0010);
    vecs[7]  = mk(8'h2D, 8'h00, 8'h00, 8'h00, 2, 0, 1, 4'b1101, 7'd0, 4'b0010);
    vecs[8]  = mk(8'hE1, 8'h81, 8'h00, 8'h00, 2, 0, 1, 4'b0001, 7'd1, 4'b0011);
    vecs[9]  = mk(8'h2D, 8'h00, 8'h10, 8'h2D, 4, 0, 1, 4'b1101, 7'd0, 4'b0000);
    vecs[10] = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'b1101, 7'd0, 4'b0000);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      v0 = n_valid;
      e0 = n_err;
      for (int k = 0; k < int'(vecs[i].nb); k++) send_byte(vecs[i].b[k]);
      send_eop();
      repeat (4) @(negedge clk);
      check($sformatf("v%0d valid_cnt", i), n_valid - v0, vecs[i].ev);
      check($sformatf("v%0d err_cnt", i),   n_err - e0,   vecs[i].ee);
      check($sformatf("v%0d pid", i),  bus.token_pid,  vecs[i].pid);
      check($sformatf("v%0d addr", i), bus.token_addr, vecs[i].addr);
      check($sformatf("v%0d endp", i), bus.token_endp, vecs[i].endp);
      check($sformatf("v%0d busy", i), bus.busy, 0);
    end

    // Result latency: eop one cycle into SHIFT2, pulse right after CHECK.
    send_byte(8'h2D);
    send_byte(8'h00);
    bus.byte_valid = 1'b1;
    bus.rcv_byte   = 8'h10;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.eop        = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    repeat (7) @(negedge clk);
    check("lat check_state valid", bus.token_valid, 0);
    check("lat check_state busy",  bus.busy, 1);
    @(negedge clk);
    check("lat pulse valid", bus.token_valid, 1);
    check("lat pulse err",   bus.token_err, 0);
    @(negedge clk);
    check("lat after valid", bus.token_valid, 0);
    check("lat after busy",  bus.busy, 0);
    repeat (2) @(negedge clk);

    // Overrun: extra byte 3 cycles into SHIFT1.
    v0 = n_valid;
    e0 = n_err;
    send_byte(8'h2D);
    bus.byte_valid = 1'b1;
    bus.rcv_byte   = 8'h00;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.rcv_byte   = 8'h10;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check("ovr err pulse", bus.token_err, 1);
    check("ovr busy", bus.busy, 1);
    send_byte(8'h10);
    check("ovr ignore busy", bus.busy, 1);
    send_eop();
    repeat (3) @(negedge clk);
    check("ovr busy after eop", bus.busy, 0);
    check("ovr err_cnt", n_err - e0, 1);
    check("ovr valid_cnt", n_valid - v0, 0);

    // Reset in SHIFT2 with nonzero fields, then a clean packet.
    v0 = n_valid;
    e0 = n_err;
    send_byte(8'hE1);
    send_byte(8'h81);
    bus.byte_valid = 1'b1;
    bus.rcv_byte   = 8'h58;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst pid",  bus.token_pid, 4'b0001);
    check("pre_rst busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst no valid", n_valid - v0, 0);
    check("rst no err",   n_err - e0, 0);
    send_byte(8'h2D);
    send_byte(8'h00);
    send_byte(8'h10);
    send_eop();
    repeat (4) @(negedge clk);
    check("post_rst valid_cnt", n_valid - v0, 1);
    check("post_rst err_cnt",   n_err - e0, 0);
    check("post_rst pid",  bus.token_pid, 4'b1101);
    check("post_rst addr", bus.token_addr, 0);
    check("post_rst endp", bus.token_endp, 0);

    check("no_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
